// File: rtl/span_param_loader_if.sv
// Parameter-stream, span_cme register-bus and result-stream bundle for span_param_loader.
// The loader connects through the slave modport; its environment uses the master modport.
interface span_param_loader_if #(
  parameter int DATA_W = 16,
  parameter int OFF_W  = 6
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;
  logic [DATA_W-1:0] writeData;
  logic [OFF_W-1:0]  offset;
  logic              write;
  logic              chipselect;
  logic              read;
  logic [DATA_W-1:0] readData;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_ready;
  logic              busy;
  logic              err;

  modport slave (
    input  s_data, s_valid, s_last, readData, r_ready,
    output s_ready, writeData, offset, write, chipselect, read, r_data, r_valid, busy, err
  );

  modport master (
    output s_data, s_valid, s_last, readData, r_ready,
    input  s_ready, writeData, offset, write, chipselect, read, r_data, r_valid, busy, err
  );
endinterface

// File: rtl/span_param_loader.sv
// Buffers one SPAN parameter record, replays it onto the span_cme register bus,
// waits out the compute interval and streams the result registers back out.
module span_param_loader #(
  parameter int NUM_REGS     = 34,
  parameter int DATA_W       = 16,
  parameter int OFF_W        = 6,
  parameter int COMPUTE_WAIT = 200,
  parameter int RESULT_BASE  = 34,
  parameter int NUM_RESULTS  = 2
) (
  input  logic                clk,
  input  logic                reset,
  span_param_loader_if.slave  bus
);

  localparam int MAX_CNT = (NUM_REGS > COMPUTE_WAIT) ? NUM_REGS : COMPUTE_WAIT;
  localparam int CNT_W   = $clog2(MAX_CNT);
  localparam int IDX_W   = $clog2(NUM_REGS);
  localparam int J_W     = (NUM_RESULTS > 1) ? $clog2(NUM_RESULTS) : 1;

  localparam logic [CNT_W-1:0] LAST_REG  = CNT_W'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(COMPUTE_WAIT - 1);
  localparam logic [J_W-1:0]   LAST_J    = J_W'(NUM_RESULTS - 1);

  if (RESULT_BASE + NUM_RESULTS - 1 >= (1 << OFF_W)) begin : g_offset_range
    $error("span_param_loader: result offsets do not fit in OFF_W bits");
  end

  typedef enum logic [2:0] {
    S_FILL, S_DRAIN, S_WRITE, S_WAIT, S_RD_REQ, S_RD_CAP, S_OUT
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [J_W-1:0]    j_q, j_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];

  logic              s_ready_q, s_ready_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              write_q, write_d;
  logic              read_q, read_d;
  logic              cs_q, cs_d;
  logic [OFF_W-1:0]  offset_q, offset_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              r_valid_q, r_valid_d;
  logic [DATA_W-1:0] r_data_q;

  logic hs_in, hs_out;

  assign hs_in  = bus.s_valid && s_ready_q;
  assign hs_out = r_valid_q && bus.r_ready;

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    j_d     = j_q;
    err_d   = 1'b0;

    case (state_q)
      S_FILL: if (hs_in) begin
        if (bus.s_last) begin
          cnt_d = '0;
          if (cnt_q == LAST_REG) state_d = S_WRITE;
          else                   err_d   = 1'b1;
        end else if (cnt_q == LAST_REG) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: if (hs_in && bus.s_last) begin
        cnt_d   = '0;
        state_d = S_FILL;
      end
      S_WRITE: begin
        if (cnt_q == LAST_REG) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (cnt_q == LAST_WAIT) begin
          cnt_d   = '0;
          state_d = S_RD_REQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RD_REQ: state_d = S_RD_CAP;
      S_RD_CAP: state_d = S_OUT;
      S_OUT: if (hs_out) begin
        if (j_q == LAST_J) begin
          j_d     = '0;
          state_d = S_FILL;
        end else begin
          j_d     = j_q + J_W'(1);
          state_d = S_RD_REQ;
        end
      end
      default: begin
        cnt_d   = '0;
        j_d     = '0;
        state_d = S_FILL;
      end
    endcase

    // Outputs are decoded from the next state so the registered bus lines up with it.
    s_ready_d = (state_d == S_FILL) || (state_d == S_DRAIN);
    busy_d    = (state_d != S_FILL);
    r_valid_d = (state_d == S_OUT);
    write_d   = 1'b0;
    read_d    = 1'b0;
    cs_d      = 1'b0;
    offset_d  = '0;
    wdata_d   = '0;
    if (state_d == S_WRITE) begin
      write_d  = 1'b1;
      cs_d     = 1'b1;
      offset_d = OFF_W'(cnt_d);
      wdata_d  = regs_q[cnt_d[IDX_W-1:0]];
    end else if (state_d == S_RD_REQ) begin
      read_d   = 1'b1;
      cs_d     = 1'b1;
      offset_d = OFF_W'(RESULT_BASE) + OFF_W'(j_d);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FILL;
      cnt_q     <= '0;
      j_q       <= '0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      write_q   <= 1'b0;
      read_q    <= 1'b0;
      cs_q      <= 1'b0;
      offset_q  <= '0;
      wdata_q   <= '0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      j_q       <= j_d;
      s_ready_q <= s_ready_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      write_q   <= write_d;
      read_q    <= read_d;
      cs_q      <= cs_d;
      offset_q  <= offset_d;
      wdata_q   <= wdata_d;
      r_valid_q <= r_valid_d;
      if (state_q == S_RD_CAP) r_data_q <= bus.readData;
    end
  end

  // NOTE: the record buffer is storage only, so it has no reset; reset just blocks writes.
  always_ff @(posedge clk) begin
    if (!reset && state_q == S_FILL && hs_in) regs_q[cnt_q[IDX_W-1:0]] <= bus.s_data;
  end

  assign bus.s_ready    = s_ready_q;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;
  assign bus.write      = write_q;
  assign bus.read       = read_q;
  assign bus.chipselect = cs_q;
  assign bus.offset     = offset_q;
  assign bus.writeData  = wdata_q;
  assign bus.r_valid    = r_valid_q;
  assign bus.r_data     = r_data_q;

endmodule

// File: tb/tb_span_param_loader.sv
// Directed-plus-random bench for span_param_loader with a behavioural span_cme stand-in
// and a bus monitor that logs every write/read transaction with its cycle number.
module tb_span_param_loader;
  localparam int DATA_W       = 16;
  localparam int OFF_W        = 6;
  localparam int NUM_REGS     = 34;
  localparam int COMPUTE_WAIT = 200;
  localparam int RESULT_BASE  = 34;
  localparam int NUM_RESULTS  = 2;

  typedef logic [DATA_W-1:0] word_q_t[$];
  typedef struct {
    int                cyc;
    logic [OFF_W-1:0]  off;
    logic [DATA_W-1:0] data;
  } bus_ev_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  span_param_loader_if #(.DATA_W(DATA_W), .OFF_W(OFF_W)) bus ();

  span_param_loader #(
    .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .OFF_W(OFF_W),
    .COMPUTE_WAIT(COMPUTE_WAIT), .RESULT_BASE(RESULT_BASE), .NUM_RESULTS(NUM_RESULTS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int err_cnt     = 0;
  int err_cyc     = -1;
  int last_hs_cyc = 0;
  int hs_cycs[$];
  bus_ev_t wq[$];
  bus_ev_t rq[$];
  word_q_t rec;
  logic             rd_seen = 1'b0;
  logic [OFF_W-1:0] rd_off  = '0;

  word_q_t nom_rec = '{16'd96, 16'd10, 16'd15, 16'hFFFB, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0,
                       16'd3, 16'd1, 16'd5, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd2, 16'd4,
                       16'd6, 16'd50, 16'd60, 16'd70, 16'd80, 16'd90, 16'd100, 16'd100,
                       16'd110, 16'd120, 16'd1750, 16'd2500, 16'd2, 16'd1, 16'd55};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // span_cme stand-in: each result register is a checksum of the loaded record tagged by offset.
  function automatic logic [DATA_W-1:0] cme_result(input logic [OFF_W-1:0] off);
    logic [DATA_W-1:0] s = '0;
    foreach (rec[i]) s += rec[i];
    return s ^ (DATA_W'(off) * 16'h0101);
  endfunction

  function automatic word_q_t rand_words(input int n);
    word_q_t w;
    for (int i = 0; i < n; i++) w.push_back(DATA_W'($urandom));
    return w;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    rd_seen = bus.read;
    rd_off  = bus.offset;
    if (bus.write) wq.push_back('{cyc, bus.offset, bus.writeData});
    if (bus.read)  rq.push_back('{cyc, bus.offset, '0});
    if (bus.err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    check("rw_exclusive", bus.write & bus.read, 0);
    check("chipselect_decode", bus.chipselect, bus.write | bus.read);
  end

  // readData is meaningful only in the cycle after a read; garbage otherwise.
  always @(posedge clk) begin
    #1;
    bus.readData = rd_seen ? cme_result(rd_off) : DATA_W'($urandom);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_word(input logic [DATA_W-1:0] d, input logic last, input bit bubble);
    int waited = 0;
    bus.s_data  = d;
    bus.s_last  = last;
    bus.s_valid = 1'b1;
    while (bus.s_ready !== 1'b1 && waited < 1000) begin
      step();
      waited++;
    end
    check("s_ready_wait", waited < 1000, 1);
    last_hs_cyc = cyc;
    step();
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    if (bubble) step();
  endtask

  task automatic send_record(input word_q_t words, input int last_idx, input bit bubble);
    hs_cycs.delete();
    foreach (words[i]) begin
      send_word(words[i], i == last_idx, bubble);
      hs_cycs.push_back(last_hs_cyc);
    end
  endtask

  task automatic run_record(input word_q_t words, input int hold, input bit bubble);
    int h, rv_exp, hs, waited, err_before;
    rec = words;
    wq.delete();
    rq.delete();
    err_before  = err_cnt;
    bus.r_ready = (hold == 0);
    send_record(words, words.size() - 1, bubble);
    h      = last_hs_cyc;
    rv_exp = h + NUM_REGS + COMPUTE_WAIT + 3;
    for (int j = 0; j < NUM_RESULTS; j++) begin
      waited = 0;
      while (bus.r_valid !== 1'b1 && waited < 600) begin
        step();
        waited++;
      end
      check("r_valid_wait", waited < 600, 1);
      check("r_valid_cycle", cyc, rv_exp);
      check("read_count", rq.size(), j + 1);
      if (rq.size() > j) begin
        check("read_offset", rq[j].off, RESULT_BASE + j);
        check("read_cycle", rq[j].cyc, rv_exp - 2);
      end
      check("r_data", bus.r_data, cme_result(OFF_W'(RESULT_BASE + j)));
      if (j == 0) begin
        for (int k = 0; k < hold; k++) begin
          step();
          check("hold_r_valid", bus.r_valid, 1);
          check("hold_r_data", bus.r_data, cme_result(OFF_W'(RESULT_BASE)));
          check("hold_s_ready", bus.s_ready, 0);
          check("hold_read_count", rq.size(), 1);
        end
      end
      bus.r_ready = 1'b1;
      hs = cyc;
      step();
      rv_exp = hs + 3;
    end
    check("s_ready_return", bus.s_ready, 1);
    check("busy_idle", bus.busy, 0);
    check("write_count", wq.size(), NUM_REGS);
    for (int k = 0; k < wq.size() && k < NUM_REGS; k++) begin
      check("write_offset", wq[k].off, k);
      check("write_data", wq[k].data, words[k]);
      check("write_cycle", wq[k].cyc, h + 1 + k);
    end
    check("err_quiet", err_cnt, err_before);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    word_q_t w;
    int e0, h;
    bus.s_data  = '0;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.r_ready = 1'b1;
    reset       = 1'b1;
    repeat (3) step();

    check("rst_s_ready", bus.s_ready, 0);
    check("rst_writeData", bus.writeData, 0);
    check("rst_offset", bus.offset, 0);
    check("rst_write", bus.write, 0);
    check("rst_chipselect", bus.chipselect, 0);
    check("rst_read", bus.read, 0);
    check("rst_r_data", bus.r_data, 0);
    check("rst_r_valid", bus.r_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_err", bus.err, 0);
    reset = 1'b0;
    step();
    check("s_ready_after_reset", bus.s_ready, 1);

    // Nominal record, then result back-pressure.
    run_record(nom_rec, 0, 1'b0);
    run_record(rand_words(NUM_REGS), 10, 1'b0);

    // Short record: s_last on word 20.
    wq.delete();
    e0 = err_cnt;
    send_record(rand_words(20), 19, 1'b0);
    check("short_err_cycle", err_cyc, hs_cycs[19] + 1);
    repeat (5) step();
    check("short_err_once", err_cnt, e0 + 1);
    check("short_no_writes", wq.size(), 0);
    check("short_s_ready", bus.s_ready, 1);
    run_record(rand_words(NUM_REGS), 0, 1'b0);

    // Long record: 40 words, s_last on word 40.
    wq.delete();
    e0 = err_cnt;
    send_record(rand_words(40), 39, 1'b0);
    check("long_err_cycle", err_cyc, hs_cycs[33] + 1);
    check("long_drain_rate", hs_cycs[39], hs_cycs[33] + 6);
    check("long_s_ready", bus.s_ready, 1);
    check("long_busy", bus.busy, 0);
    repeat (5) step();
    check("long_err_once", err_cnt, e0 + 1);
    check("long_no_writes", wq.size(), 0);
    run_record(rand_words(NUM_REGS), 0, 1'b0);

    // Reset at WAIT cycle 50.
    w   = rand_words(NUM_REGS);
    rec = w;
    wq.delete();
    rq.delete();
    send_record(w, NUM_REGS - 1, 1'b0);
    h = last_hs_cyc;
    while (cyc < h + 1 + NUM_REGS + 50) step();
    reset       = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 16'hDEAD;
    step();
    check("wait_rst_write", bus.write, 0);
    check("wait_rst_read", bus.read, 0);
    check("wait_rst_chipselect", bus.chipselect, 0);
    check("wait_rst_s_ready", bus.s_ready, 0);
    check("wait_rst_busy", bus.busy, 0);
    reset       = 1'b0;
    bus.s_valid = 1'b0;
    step();
    check("wait_rst_s_ready_rise", bus.s_ready, 1);
    check("wait_rst_writes_done", wq.size(), NUM_REGS);
    repeat (300) step();
    check("wait_rst_no_reads", rq.size(), 0);
    run_record(rand_words(NUM_REGS), 0, 1'b0);

    // Input bubbles.
    run_record(rand_words(NUM_REGS), 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/span_param_loader.md
# span_param_loader

Upstream feeder for `span_cme`. It accepts one portfolio record of 34 16-bit SPAN parameter words (price, volatility, scan ranges, deltas, and the rest) as a valid/ready stream and buffers it. It then replays the record onto the `span_cme` register write bus at offsets 0..33, waits a fixed compute interval, reads back the result registers, and presents each result on an output valid/ready stream. Sits between the HPS/DMA parameter FIFO and `span_cme`.

## Interface
Parameters:
- `NUM_REGS`, 34, number of parameter words per record (offsets 0..NUM_REGS-1)
- `DATA_W`, 16, bus and word width
- `OFF_W`, 6, offset width
- `COMPUTE_WAIT`, 200, idle cycles between the last write and the first read
- `RESULT_BASE`, 34, offset of the first result register
- `NUM_RESULTS`, 2, result registers read per record

Ports:
- `clk`  in  1  single clock; all logic on the rising edge
- `reset`  in  1  synchronous, active-high
- `s_data`  in  DATA_W  parameter word
- `s_valid`  in  1  word valid
- `s_last`  in  1  marks the final word of a record
- `s_ready`  out  1  loader accepts the word
- `writeData`  out  DATA_W  to `span_cme` writeData
- `offset`  out  OFF_W  to `span_cme` offset
- `write`  out  1  to `span_cme` write
- `chipselect`  out  1  to `span_cme` chipselect
- `read`  out  1  to `span_cme` read
- `readData`  in  DATA_W  from `span_cme`; valid the cycle after `read`
- `r_data`  out  DATA_W  result word
- `r_valid`  out  1  result valid
- `r_ready`  in  1  result consumer ready
- `busy`  out  1  high in every state except FILL
- `err`  out  1  one-cycle framing-error pulse

## Operation
- State FILL:
  - `s_ready=1`.
  - Each handshake (`s_valid&&s_ready`) stores `s_data` into `buf[cnt]` and increments `cnt`.
- Record completion:
  - Word with `s_last=1` and `cnt==NUM_REGS-1`: go to WRITE, `cnt` cleared.
  - `s_last=1` with `cnt<NUM_REGS-1` (short record): `err` pulses, `cnt` is cleared, stay in FILL. The record is discarded.
  - Word `cnt==NUM_REGS-1` with `s_last=0` (long record): `err` pulses, go to DRAIN.
- State DRAIN:
  - `s_ready=1`; words are discarded.
  - The handshake with `s_last=1` is discarded and returns to FILL with `cnt=0`.
- State WRITE: NUM_REGS consecutive cycles, k=0..NUM_REGS-1 ascending.
  - `chipselect=1`, `write=1`, `offset=k`, `writeData=buf[k]`.
  - No gaps and no back-pressure from `span_cme`.
- State WAIT:
  - Exactly COMPUTE_WAIT cycles.
  - All bus strobes 0; `offset` and `writeData` held at 0.
- For each result j=0..NUM_RESULTS-1, three states in turn:
  - RD_REQ, one cycle: `chipselect=1`, `read=1`, `offset=RESULT_BASE+j`.
  - RD_CAP, one cycle: strobes 0; `readData` is registered into `r_data`.
  - OUT: `r_valid=1`. `r_data` stays stable until `r_ready`. On the handshake, advance to j+1 (RD_REQ), or to FILL after the last result.
- `s_ready=0` in WRITE, WAIT, RD_REQ, RD_CAP and OUT. A new record can only be accepted after the last result is consumed.
- `write` and `read` are never both high. `chipselect` is high only when one of them is high.
- Offsets are OFF_W bits wide; RESULT_BASE+NUM_RESULTS-1 must fit in OFF_W bits (checked by elaboration assertion).

## Timing
- Reset values: `s_ready=0`, `writeData=0`, `offset=0`, `write=0`, `chipselect=0`, `read=0`, `r_data=0`, `r_valid=0`, `busy=0`, `err=0`. State=FILL, `cnt=0`, j=0.
- `s_ready` rises the first cycle after `reset` deasserts.
- All bus outputs are registered.
- First WRITE cycle (offset 0) is the cycle after the final word handshake.
- WRITE is offsets 0..33 on 34 consecutive cycles, then 200 WAIT cycles.
- First `read` occurs NUM_REGS+COMPUTE_WAIT+1 cycles after the final word handshake (235 at defaults).
- `r_valid` rises 2 cycles after its `read` strobe.
- With `r_ready` tied high:
  - each result costs 3 cycles;
  - `s_ready` returns the cycle after the last `r_valid` handshake.
- `err` is high for exactly the cycle after the offending handshake.
- Reset mid-operation (any state): the next cycle has all strobes 0, state FILL, `cnt=0`. `buf` contents are not cleared. Any partial bus burst is abandoned.
- Simultaneous `reset` and `s_valid`: reset wins; the word is not stored.

## Test plan
- **Nominal record.** Stream 96,10,15,0xFFFB,0,0,0,0,0,3,1,5,0,0,0,0,0,2,4,6,50,60,70,80,90,100,100,110,120,1750,2500,2,1,55 with `s_last` on word 34.
  - Required: 34 back-to-back writes at offsets 0..33 with exactly those values.
  - Then 200 idle cycles.
  - Then reads at offsets 34 and 35; `r_data` equals the modelled `readData`.
- **Back-pressure on results.** Hold `r_ready=0` for 10 cycles on result 0.
  - Required: `r_valid` and `r_data` stay stable; no second `read` until the handshake; `s_ready=0` throughout.
- **Short record.** `s_last` on word 20.
  - Required: `err` pulses once; no bus writes; the next well-formed 34-word record loads normally with offset 0 taking its first word.
- **Long record.** 40 words with `s_last` on word 40.
  - Required: `err` pulses after word 34; words 35..40 discarded; no writes; FILL with `cnt=0` afterwards.
- **Reset during WAIT.** Assert `reset` at WAIT cycle 50.
  - Required: no `read` ever issued for that record; `s_ready=1` the cycle after reset deasserts; a fresh record completes normally.
- **Bubbles on input.** `s_valid` toggled 1/0 each cycle.
  - Required: all 34 words captured in order; WRITE starts the cycle after the 34th handshake.
